seg7_capture: RTL and testbench

Reader for the multiplexed, active-low 7-segment display bus that our display driver produces. Watches the segment lines and digit selects, waits for each digit pattern to be stable, decodes it back to a 4-bit code, and assembles a full frame of `DIGITS` codes. Completed frames leave through a valid/ready handshake. Used on the verification/loopback side to check what the correlator actually shows on the display.

---
 rtl/seg7_capture_if.sv | 26 ++
 rtl/seg7_capture.sv | 208 ++++++++++++++++++++
 tb/tb_seg7_capture.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_capture_if.sv
// Frame output bus of seg7_capture: decoded digit codes, error flag, valid/ready and sticky overflow.
interface seg7_capture_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] out_codes;
  logic                out_err;
  logic                out_valid;
  logic                out_ready;
  logic                out_overflow;

  modport master (
    output out_codes,
    output out_err,
    output out_valid,
    output out_overflow,
    input  out_ready
  );

  modport slave (
    input  out_codes,
    input  out_err,
    input  out_valid,
    input  out_overflow,
    output out_ready
  );
endinterface

// File: rtl/seg7_capture.sv
// Decodes a multiplexed active-low 7-segment bus back into frames of DIGITS 4-bit codes.
// Optional macro SEG7_CAP_DEDUP_EN drops frames identical to the last one accepted on the handshake.
module seg7_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg_in,
  input  logic [DIGITS-1:0] an_in,
  seg7_capture_if.master    frm
);

  localparam int         AW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] CNT_HIT = 8'(STABLE_CYCLES - 1);

  typedef enum logic {ST_COLLECT, ST_HOLD} state_t;

  // Returns {err, code}; unknown patterns decode to 14 with err set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: return 5'h00;
      7'b1111001: return 5'h01;
      7'b0100100: return 5'h02;
      7'b0110000: return 5'h03;
      7'b0011001: return 5'h04;
      7'b0010010: return 5'h05;
      7'b0000010: return 5'h06;
      7'b1111000: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0010000: return 5'h09;
      7'b0000110: return 5'h0A;
      7'b1111111: return 5'h0F;
      default:    return 5'h1E;
    endcase
  endfunction

  function automatic logic sel_one(input logic [DIGITS-1:0] an);
    int n;
    n = 0;
    for (int i = 0; i < DIGITS; i++)
      if (!an[i]) n++;
    return (n == 1);
  endfunction

  function automatic logic [AW-1:0] sel_idx(input logic [DIGITS-1:0] an);
    logic [AW-1:0] idx;
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (!an[i]) idx = AW'(i);
    return idx;
  endfunction

  logic [6:0]          r_seg_p0;
  logic [DIGITS-1:0]   r_an_p0;
  logic [7:0]          r_cnt;
  logic                r_committed;
  logic                w_same;
  logic                w_commit;
  logic [4:0]          w_dec;
  logic [AW-1:0]       w_idx;
  logic [DIGITS-1:0]   w_mask;

  logic [3:0]          r_slot_p1 [DIGITS];
  logic [DIGITS-1:0]   r_slot_err_p1;
  logic [DIGITS-1:0]   r_seen;
  logic                w_full;
  logic [4*DIGITS-1:0] w_frame_codes;
  logic                w_frame_err;

  logic [4*DIGITS-1:0] r_codes_p2;
  logic                r_err_p2;
  logic                r_ovf;
  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_hs;
  logic                w_dup;
  logic                w_load;
  logic                w_clear;
  logic                w_ovf_set;

  // Stage p0: sample register and stability counter
  assign w_same = (seg_in == r_seg_p0) && (an_in == r_an_p0);

  always_ff @(posedge clk) begin
    r_seg_p0 <= seg_in;
    r_an_p0  <= an_in;
    if (rst) begin
      r_cnt       <= 8'd0;
      r_committed <= 1'b0;
    end else if (!w_same) begin
      r_cnt       <= 8'd0;
      r_committed <= 1'b0;
    end else begin
      if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      if (r_cnt == CNT_HIT) r_committed <= 1'b1;
    end
  end

  assign w_commit = (r_cnt == CNT_HIT) && !r_committed && sel_one(r_an_p0);
  assign w_dec    = decode(r_seg_p0);
  assign w_idx    = sel_idx(r_an_p0);
  assign w_mask   = w_commit ? (DIGITS'(1) << w_idx) : '0;

  // Stage p1: per-digit slots and seen tracking
  always_ff @(posedge clk) begin
    if (w_commit) r_slot_p1[w_idx] <= w_dec[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seen        <= '0;
      r_slot_err_p1 <= '0;
    end else begin
      // A commit landing on the clearing edge belongs to the next frame.
      r_seen        <= (w_clear ? '0 : r_seen) | w_mask;
      r_slot_err_p1 <= ((w_clear ? '0 : r_slot_err_p1) & ~w_mask) | (w_dec[4] ? w_mask : '0);
    end
  end

  assign w_full = &r_seen;

  always_comb begin
    w_frame_codes = '0;
    for (int i = 0; i < DIGITS; i++)
      w_frame_codes[4*i +: 4] = r_slot_p1[i];
  end

  assign w_frame_err = |r_slot_err_p1;
  assign w_hs        = (r_state == ST_HOLD) && frm.out_ready;

`ifdef SEG7_CAP_DEDUP_EN
  logic [4*DIGITS-1:0] r_last_codes;
  logic                r_last_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_codes <= '1;
      r_last_err   <= 1'b0;
    end else if (w_hs) begin
      r_last_codes <= r_codes_p2;
      r_last_err   <= r_err_p2;
    end
  end

  // The frame being accepted this cycle is the reference for a simultaneous completion.
  assign w_dup = w_hs ? ({w_frame_codes, w_frame_err} == {r_codes_p2, r_err_p2})
                      : ({w_frame_codes, w_frame_err} == {r_last_codes, r_last_err});
`else
  assign w_dup = 1'b0;
`endif

  // Stage p2: frame FSM and output register
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_ovf_set   = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (w_full) begin
          w_clear = 1'b1;
          if (!w_dup) begin
            w_load      = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (w_full) begin
          w_clear = 1'b1;
          if (w_dup) begin
            if (w_hs) w_state_nxt = ST_COLLECT;
          end else if (w_hs) begin
            w_load = 1'b1;
          end else begin
            w_ovf_set = 1'b1;
          end
        end else if (w_hs) begin
          w_state_nxt = ST_COLLECT;
        end
      end
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_COLLECT;
      r_codes_p2 <= '1;
      r_err_p2   <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_codes_p2 <= w_frame_codes;
        r_err_p2   <= w_frame_err;
      end
      if (w_ovf_set) r_ovf <= 1'b1;
    end
  end

  assign frm.out_codes    = r_codes_p2;
  assign frm.out_err      = r_err_p2;
  assign frm.out_valid    = (r_state == ST_HOLD);
  assign frm.out_overflow = r_ovf;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture (DIGITS=4, STABLE_CYCLES=4) with a run-length reference model.
module tb_seg7_capture;

  localparam int STAB = 4;

  logic       clk;
  logic       rst;
  logic [6:0] seg;
  logic [3:0] an;
  logic       ready;

  seg7_capture_if #(.DIGITS(4)) bus ();
  assign bus.out_ready = ready;

  seg7_capture #(.DIGITS(4), .STABLE_CYCLES(STAB)) dut (
    .clk    (clk),
    .rst    (rst),
    .seg_in (seg),
    .an_in  (an),
    .frm    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Patterns for 0..9, 'E', blank
  logic [6:0] PATS [12] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                            7'b0000110, 7'b1111111};

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  // Reference model state
  int          run;
  logic [6:0]  p_seg;
  logic [3:0]  p_an;
  logic [3:0]  m_slot [4];
  logic [3:0]  m_seen;
  logic [3:0]  m_serr;
  logic [15:0] m_codes;
  logic        m_err;
  logic        m_valid;
  logic        m_ovf;
  logic [15:0] m_last;
  logic        m_last_err;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int k = 0; k < 12; k++)
      if (PATS[k] == s) return (k == 11) ? 5'h0F : 5'(k);
    return 5'h1E;
  endfunction

  task automatic model_step();
    logic        hs, full, commit, dup;
    logic [15:0] fc, old_codes;
    logic        fe, old_err;
    logic [4:0]  d;
    int          ci;
    if (rst) begin
      m_codes = 16'hFFFF; m_err = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
      m_seen = 4'h0; m_serr = 4'h0; m_last = 16'hFFFF; m_last_err = 1'b0;
      run = 1; p_seg = seg; p_an = an;
      return;
    end
    hs        = m_valid && ready;
    full      = (m_seen == 4'hF);
    commit    = (run == STAB) && ($countones(~p_an) == 1);
    old_codes = m_codes;
    old_err   = m_err;
    if (full) begin
      fc  = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
      fe  = |m_serr;
      dup = 1'b0;
`ifdef SEG7_CAP_DEDUP_EN
      dup = hs ? ({fc, fe} == {old_codes, old_err}) : ({fc, fe} == {m_last, m_last_err});
`endif
      if (dup) begin
        if (hs) m_valid = 1'b0;
      end else if (!m_valid || hs) begin
        m_codes = fc; m_err = fe; m_valid = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
      m_seen = 4'h0;
      m_serr = 4'h0;
    end else if (hs) begin
      m_valid = 1'b0;
    end
    if (hs) begin
      m_last = old_codes; m_last_err = old_err;
    end
    if (commit) begin
      ci = 0;
      for (int k = 0; k < 4; k++) if (!p_an[k]) ci = k;
      d = ref_decode(p_seg);
      m_slot[ci] = d[3:0];
      m_seen[ci] = 1'b1;
      m_serr[ci] = d[4];
    end
    if (seg == p_seg && an == p_an) begin
      if (run < 1000) run++;
    end else begin
      run = 1;
    end
    p_seg = seg;
    p_an  = an;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (bus.out_valid === 1'b1) vcount++;
    chk("valid", 16'(bus.out_valid), 16'(m_valid));
    chk("codes", bus.out_codes, m_codes);
    chk("err", 16'(bus.out_err), 16'(m_err));
    chk("overflow", 16'(bus.out_overflow), 16'(m_ovf));
  endtask

  task automatic show_an(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) tick();
  endtask

  task automatic show(input int d, input logic [6:0] s, input int n);
    show_an(~(4'd1 << d), s, n);
  endtask

  task automatic idle(input int n);
    show_an(4'hF, 7'h7F, n);
  endtask

  int base;
  int r;

  initial begin
    rst = 1'b1; seg = 7'h7F; an = 4'hF; ready = 1'b1;
    repeat (3) tick();
    chk("rst_codes", bus.out_codes, 16'hFFFF);
    chk("rst_valid", 16'(bus.out_valid), 16'h0);
    rst = 1'b0;
    idle(2);

    // Basic frame 4321
    base = vcount;
    show(0, PATS[1], 6); show(1, PATS[2], 6); show(2, PATS[3], 6); show(3, PATS[4], 6);
    chk("basic_codes", bus.out_codes, 16'h4321);
    chk("basic_vcycles", 16'(vcount - base), 16'd1);
    idle(3);

    // Glitch: 8 for 3 cycles then 7 on digit 2
    base = vcount;
    show(0, PATS[0], 6); show(1, PATS[0], 6);
    show(2, 7'b0000000, 3); show(2, 7'b1111000, 6);
    show(3, PATS[0], 6);
    chk("glitch_codes", bus.out_codes, 16'h0700);
    chk("glitch_vcycles", 16'(vcount - base), 16'd1);
    idle(3);

    // Unknown pattern and blank
    show(0, 7'b1010101, 6); show(1, 7'b1111111, 6); show(2, 7'b0000110, 6); show(3, 7'b0000110, 6);
    chk("errfrm_codes", bus.out_codes, 16'hAAFE);
    chk("errfrm_err", 16'(bus.out_err), 16'h1);
    idle(3);

    // Backpressure and overflow
    ready = 1'b0;
    for (int d = 0; d < 4; d++) show(d, PATS[1], 6);
    for (int d = 0; d < 4; d++) show(d, PATS[2], 6);
    chk("bp_codes", bus.out_codes, 16'h1111);
    chk("bp_ovf", 16'(bus.out_overflow), 16'h1);
    chk("bp_valid", 16'(bus.out_valid), 16'h1);
    ready = 1'b1;
    idle(1);
    chk("bp_drop", 16'(bus.out_valid), 16'h0);
    chk("bp_ovf_sticky", 16'(bus.out_overflow), 16'h1);
    idle(2);

    // Invalid selects
    base = vcount;
    show_an(4'b0000, PATS[5], 10);
    show_an(4'b0011, PATS[5], 10);
    idle(3);
    chk("badsel_noframe", 16'(vcount - base), 16'd0);

    // Reset mid-frame
    show(0, PATS[7], 6); show(1, PATS[8], 6);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_ovf_clear", 16'(bus.out_overflow), 16'h0);
    base = vcount;
    show(2, PATS[7], 6); show(3, PATS[6], 6);
    idle(3);
    chk("rst_partial_lost", 16'(vcount - base), 16'd0);
    show(0, PATS[9], 6); show(1, PATS[8], 6); show(2, PATS[7], 6); show(3, PATS[6], 6);
    chk("rst_frame_codes", bus.out_codes, 16'h6789);
    chk("rst_frame_cnt", 16'(vcount - base), 16'd1);
    idle(3);

    // Identical repeat frame
    base = vcount;
    show(0, PATS[9], 6); show(1, PATS[8], 6); show(2, PATS[7], 6); show(3, PATS[6], 6);
    idle(3);
`ifdef SEG7_CAP_DEDUP_EN
    chk("dedup_repeat", 16'(vcount - base), 16'd0);
`else
    chk("repeat_delivered", 16'(vcount - base), 16'd1);
`endif

    // Randomized scanning
    for (int k = 0; k < 500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 8) an = ~(4'd1 << $urandom_range(0, 3));
      else an = 4'($urandom);
      if ($urandom_range(0, 99) < 85) seg = PATS[$urandom_range(0, 11)];
      else seg = 7'($urandom);
      repeat ($urandom_range(1, 7)) tick();
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
